// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle stage controller for the RV32I core.
//
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK, handshaking with the unified instruction/data memory, and
// produces the program-counter control word plus IR/RF/memory strobes.
// Keeps a retired-instruction count and halts with a sticky fault on an
// illegal opcode or a memory request that is not acknowledged in time.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   opcode        instruction bits [6:0], sampled in DECODE
//   branch_taken  ALU branch comparison, sampled in EXECUTE
//   mem_ready     memory acknowledge for the current request
//   mem_req       memory request (FETCH and MEMORY)
//   mem_we        memory write enable (STORE in MEMORY only)
//   ir_load       instruction-register load strobe
//   rf_we         register-file write enable
//   pc_control    {pc_reset, pc_enable, pc_src, jalr}
//   stage         current state code (FETCH=0 .. HALT=5)
//   fault         sticky halt flag
//   instret       retired-instruction counter
module pc_sequencer #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        rf_we,
  output logic [3:0]  pc_control,
  output logic [2:0]  stage,
  output logic        fault,
  output logic [31:0] instret
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [6:0]         r_op;
  logic               r_taken;
  logic               r_fault;
  logic [31:0]        r_instret;

  logic w_legal;
  logic w_timeout;
  logic w_mem_req;
  logic w_mem_we;
  logic w_ir_load;
  logic w_rf_we;
  logic w_retire;
  logic w_pc_src;
  logic w_jalr;
  logic w_is_mem_op;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: w_legal = 1'b1;
      default:                           w_legal = 1'b0;
    endcase
  end

  // A ready arriving on the limit cycle wins, hence the !mem_ready term.
  assign w_timeout   = (r_wait == WAIT_LIMIT) && !mem_ready;
  assign w_is_mem_op = (r_op == OP_LOAD) || (r_op == OP_STORE);

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_ir_load = 1'b0;
    w_rf_we   = 1'b0;
    w_retire  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_DECODE:  w_next = w_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: w_next = w_is_mem_op ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_op == OP_STORE);
        if (mem_ready) begin
          // A STORE has nothing to write back, so it retires on the ack.
          if (r_op == OP_STORE) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_WRITEBACK: begin
        w_rf_we  = (r_op != OP_BRANCH);
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
    w_pc_src = w_retire && ((r_op == OP_JAL) || ((r_op == OP_BRANCH) && r_taken));
    w_jalr   = w_retire && (r_op == OP_JALR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter only advances while stalled in a memory state; any state
  // change (including re-entry into FETCH after a retire) clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait    <= '0;
      r_instret <= '0;
      r_fault   <= 1'b0;
    end else begin
      if ((w_next == r_state) && ((r_state == S_FETCH) || (r_state == S_MEMORY))) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
      if (w_next == S_HALT) begin
        r_fault <= 1'b1;
      end
    end
  end

  // Instruction latches need no reset: they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) begin
      r_op <= opcode;
    end
    if (r_state == S_EXECUTE) begin
      r_taken <= branch_taken;
    end
  end

  // Reset overrides outputs combinationally so the PC clears on the same edge.
  assign mem_req    = !reset && w_mem_req;
  assign mem_we     = !reset && w_mem_we;
  assign ir_load    = !reset && w_ir_load;
  assign rf_we      = !reset && w_rf_we;
  assign pc_control = reset ? 4'b1000 : {1'b0, w_retire, w_pc_src, w_jalr};
  assign stage      = reset ? 3'd0 : r_state;
  assign fault      = !reset && r_fault;
  assign instret    = reset ? 32'd0 : r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int MAXW = 15;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] OPR   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_load;
  logic        rf_we;
  logic [3:0]  pc_control;
  logic [2:0]  stage;
  logic        fault;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [6:0]  legal_ops [9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR};

  pc_sequencer #(.MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_load      (ir_load),
    .rf_we        (rf_we),
    .pc_control   (pc_control),
    .stage        (stage),
    .fault        (fault),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with checks, then release; next cycle is a fresh FETCH.
  task automatic apply_reset(input string name);
    reset        = 1'b1;
    mem_ready    = 1'($urandom);
    opcode       = 7'($urandom);
    branch_taken = 1'($urandom);
    @(negedge clk);
    checks++;
    if ({pc_control, stage, mem_req, mem_we, ir_load, rf_we, fault} !== {4'b1000, 3'd0, 5'b0} ||
        instret !== 32'd0) begin
      errors++;
      $display("FAIL %s: pc_control=%b stage=%0d strobes=%b%b%b%b fault=%b instret=%0d, expected 1000/0/0000/0/0",
               name, pc_control, stage, mem_req, mem_we, ir_load, rf_we, fault, instret);
    end
    next_cycle();
    reset     = 1'b0;
    model_cnt = 32'd0;
  endtask

  // Reference: builds the expected stage list of one instruction from the
  // stage rules, then checks every cycle's outputs against it.
  task automatic run_instr(input string name, input logic [6:0] op, input logic tk,
                           input int fw, input int mw);
    int          q[$];
    int          mem_ack_idx;
    logic [3:0]  retire_pc;
    logic [11:0] exp_v;
    logic [11:0] act_v;
    bit          is_mem;
    for (int k = 0; k <= fw; k++) q.push_back(0);
    q.push_back(1);
    q.push_back(2);
    is_mem = (op == LD) || (op == ST);
    if (is_mem) for (int k = 0; k <= mw; k++) q.push_back(3);
    if (op != ST) q.push_back(4);
    mem_ack_idx = fw + 3 + mw;
    retire_pc   = {1'b0, 1'b1, (op == JAL) || (op == BR && tk), op == JALR};
    for (int i = 0; i < q.size(); i++) begin
      int st;
      bit last;
      st   = q[i];
      last = (i == q.size() - 1);
      opcode       = (st == 1) ? op : 7'($urandom);
      branch_taken = (st == 2) ? tk : 1'($urandom);
      if (st == 0)      mem_ready = (i == fw);
      else if (st == 3) mem_ready = (i == mem_ack_idx);
      else              mem_ready = 1'($urandom);
      exp_v = {3'(st), (st == 0) || (st == 3), (st == 3) && (op == ST), i == fw,
               (st == 4) && (op != BR), last ? retire_pc : 4'b0000, 1'b0};
      @(negedge clk);
      act_v = {stage, mem_req, mem_we, ir_load, rf_we, pc_control, fault};
      checks++;
      if (act_v !== exp_v || instret !== model_cnt) begin
        errors++;
        $display("FAIL %s cycle %0d: {stage,req,we,ir,rf,pc,fault}=%b instret=%0d, expected %b instret=%0d",
                 name, i, act_v, instret, exp_v, model_cnt);
      end
      if (last) model_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    mem_ready    = 1'b1;
    opcode       = OPR;
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (pc_control !== 4'b1000 || mem_req !== 1'b0 || stage !== 3'd0 || instret !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold %0d: pc_control=%b mem_req=%b stage=%0d instret=%0d, expected 1000/0/0/0",
                 i, pc_control, mem_req, stage, instret);
      end
      next_cycle();
    end
    reset     = 1'b0;
    model_cnt = 32'd0;
    run_instr("reset_release", OPI, 1'b0, 0, 0);
  endtask

  task automatic test_add();
    run_instr("add", OPR, 1'b0, 0, 0);
    run_instr("add_fetch_wait", OPR, 1'b1, 2, 0);
  endtask

  task automatic test_branch();
    run_instr("branch_taken", BR, 1'b1, 0, 0);
    run_instr("branch_not_taken", BR, 1'b0, 0, 0);
    run_instr("jalr", JALR, 1'b1, 0, 0);
    run_instr("jal", JAL, 1'b0, 1, 0);
  endtask

  task automatic test_load_wait();
    run_instr("load_wait3", LD, 1'b0, 0, 3);
    run_instr("load_nowait", LD, 1'b1, 0, 0);
  endtask

  task automatic test_store();
    run_instr("store", ST, 1'b0, 0, 0);
    run_instr("store_wait2", ST, 1'b1, 1, 2);
  endtask

  task automatic test_wait_boundary();
    run_instr("fetch_wait_limit", OPR, 1'b0, MAXW, 0);
    run_instr("mem_wait_limit", LD, 1'b0, 0, MAXW);
    run_instr("store_wait_limit", ST, 1'b0, MAXW, MAXW);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      logic [6:0] op;
      int fw;
      int mw;
      op = legal_ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW) : $urandom_range(0, 2);
      run_instr("random", op, 1'($urandom), fw, mw);
    end
  endtask

  // Reset lands on the STORE ack cycle: no retire and counter cleared.
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      mem_ready    = (i == 0);
      opcode       = (i == 1) ? ST : 7'($urandom);
      branch_taken = 1'($urandom);
      @(negedge clk);
      checks++;
      if (stage !== 3'(i)) begin
        errors++;
        $display("FAIL reset_mid_seq %0d: stage=%0d, expected %0d", i, stage, i);
      end
      next_cycle();
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pc_control !== 4'b1000 || mem_req !== 1'b0 || mem_we !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: pc_control=%b mem_req=%b mem_we=%b stage=%0d, expected 1000/0/0/0",
               pc_control, mem_req, mem_we, stage);
    end
    next_cycle();
    reset     = 1'b0;
    model_cnt = 32'd0;
    run_instr("after_mid_reset", OPR, 1'b0, 0, 0);
  endtask

  task automatic check_halt(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mem_ready    = 1'($urandom);
      opcode       = 7'($urandom);
      branch_taken = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({stage, mem_req, mem_we, ir_load, rf_we, pc_control, fault} !== {3'd5, 8'b0, 1'b1} ||
          instret !== model_cnt) begin
        errors++;
        $display("FAIL %s halt %0d: stage=%0d strobes=%b%b%b%b pc=%b fault=%b instret=%0d, expected 5/0000/0000/1/%0d",
                 name, i, stage, mem_req, mem_we, ir_load, rf_we, pc_control, fault, instret, model_cnt);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] bad;
    for (int t = 0; t < 2; t++) begin
      run_instr("pre_illegal", OPI, 1'b0, 0, 0);
      if (t == 0) bad = 7'b1111111;
      else begin
        bad = 7'($urandom);
        while (is_legal(bad)) bad = 7'($urandom);
      end
      for (int i = 0; i < 2; i++) begin
        mem_ready = (i == 0);
        opcode    = (i == 1) ? bad : 7'($urandom);
        @(negedge clk);
        checks++;
        if (stage !== 3'(i) || fault !== 1'b0) begin
          errors++;
          $display("FAIL illegal_seq %0d: stage=%0d fault=%b, expected %0d/0", i, stage, fault, i);
        end
        next_cycle();
      end
      check_halt("illegal", 5);
      apply_reset("illegal_reset");
    end
  endtask

  task automatic test_timeout();
    run_instr("pre_timeout", OPR, 1'b0, 0, 0);
    for (int i = 0; i <= MAXW; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (stage !== 3'd0 || mem_req !== 1'b1 || ir_load !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL fetch_timeout %0d: stage=%0d mem_req=%b ir_load=%b fault=%b, expected 0/1/0/0",
                 i, stage, mem_req, ir_load, fault);
      end
      next_cycle();
    end
    check_halt("fetch_timeout", 3);
    apply_reset("fetch_timeout_reset");
    // Timeout while a LOAD waits in MEMORY.
    for (int i = 0; i < 3 + MAXW + 1; i++) begin
      mem_ready = (i == 0);
      opcode    = (i == 1) ? LD : 7'($urandom);
      @(negedge clk);
      checks++;
      if (stage !== ((i < 3) ? 3'(i) : 3'd3) || fault !== 1'b0) begin
        errors++;
        $display("FAIL mem_timeout %0d: stage=%0d fault=%b, expected %0d/0",
                 i, stage, fault, (i < 3) ? i : 3);
      end
      next_cycle();
    end
    check_halt("mem_timeout", 3);
    apply_reset("mem_timeout_reset");
  endtask

  initial begin
    reset        = 1'b1;
    mem_ready    = 1'b0;
    opcode       = 7'd0;
    branch_taken = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_store();
    test_wait_boundary();
    test_random(40);
    test_reset_mid();
    test_illegal();
    test_timeout();
    run_instr("post_fault_recovery", JAL, 1'b0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
